lsu_bus_unit: RTL and testbench

- Load/store unit that consumes `lsu_adr` produced by the LSU address buffer.
- Runs byte or word (little-endian, two-beat) loads and stores on the core's 8-bit external memory bus, using a req/rdy handshake.
- Returns load data to the ALU/register path and signals busy to the scheduler.
- Sits directly downstream of the address buffer and upstream of the external bus.

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_adr_inc.sv | 23 ++
 rtl/lsu_bus_unit.sv | 127 ++++++++++++
 tb/tb_lsu_bus_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store bus unit and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: op encodings, FSM state encoding, default address width.
package lsu_pkg;

  localparam int LSU_ADR_W = 16;

  // sched_op: bit 1 selects store, bit 0 selects word (two-beat) access.
  typedef enum logic [1:0] {
    OP_LDB = 2'b00,
    OP_LDW = 2'b01,
    OP_STB = 2'b10,
    OP_STW = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/lsu_adr_inc.sv
// High-byte address generator: adr+1, or page-local increment when wrap is honoured.
// Latency: combinational.
// Backpressure: none.
// Ports: adr (base address), wrap (page-wrap request), adr_hi (address of the next byte).
module lsu_adr_inc #(
  parameter int ADR_W   = 16,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic [ADR_W-1:0] adr,
  input  logic             wrap,
  output logic [ADR_W-1:0] adr_hi
);

  always_comb begin
    if (WRAP_EN && wrap) begin
      // Only the in-page byte increments; the page number is preserved.
      adr_hi = {adr[ADR_W-1:8], adr[7:0] + 8'd1};
    end else begin
      adr_hi = adr + {{(ADR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/lsu_bus_unit.sv
// Load/store unit driving an 8-bit memory bus; byte ops take one beat, word ops two (low byte first).
// Latency: request at N -> mem_req at N+1, res_valid at N+2 (byte) / N+3 (word) with mem_rdy high.
// Backpressure: mem_rdy low stalls the current beat with all bus outputs held; sched_busy blocks new requests.
// Ports: clk/rst; scheduler side lsu_adr, sched_req/op/wrap/data, sched_busy, res_valid, res_data;
//        bus side mem_adr, mem_dout, mem_we, mem_req, mem_din, mem_rdy.
module lsu_bus_unit
  import lsu_pkg::*;
#(
  parameter int ADR_W   = LSU_ADR_W,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADR_W-1:0] lsu_adr,
  input  logic             sched_req,
  input  logic [1:0]       sched_op,
  input  logic             sched_wrap,
  input  logic [15:0]      sched_data,
  output logic             sched_busy,
  output logic             res_valid,
  output logic [15:0]      res_data,
  output logic [ADR_W-1:0] mem_adr,
  output logic [7:0]       mem_dout,
  output logic             mem_we,
  output logic             mem_req,
  input  logic [7:0]       mem_din,
  input  logic             mem_rdy
);

  state_t state, state_nxt;

  logic             is_st_q;
  logic             is_wd_q;
  logic [15:0]      data_q;
  logic [ADR_W-1:0] adr_lo_q;
  logic [ADR_W-1:0] adr_hi_q;
  logic [7:0]       lo_byte_q;
  logic [ADR_W-1:0] adr_hi_calc;
  logic             accept;

  lsu_adr_inc #(
    .ADR_W   (ADR_W),
    .WRAP_EN (WRAP_EN)
  ) u_adr_inc (
    .adr    (lsu_adr),
    .wrap   (sched_wrap),
    .adr_hi (adr_hi_calc)
  );

  // New work is taken only when no beat is outstanding; DONE also accepts so
  // back-to-back byte ops sustain one every two cycles.
  assign accept = sched_req && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sched_busy = 1'b0;
    res_valid  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_adr    = '0;
    mem_dout   = 8'h00;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_LO;
      end
      ST_LO: begin
        sched_busy = 1'b1;
        mem_req    = 1'b1;
        mem_we     = is_st_q;
        mem_adr    = adr_lo_q;
        mem_dout   = data_q[7:0];
        if (mem_rdy) state_nxt = is_wd_q ? ST_HI : ST_DONE;
      end
      ST_HI: begin
        sched_busy = 1'b1;
        mem_req    = 1'b1;
        mem_we     = is_st_q;
        mem_adr    = adr_hi_q;
        mem_dout   = data_q[15:8];
        if (mem_rdy) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        state_nxt = accept ? ST_LO : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch and load-data capture. res_data changes only on the edge
  // that completes the final beat of a load, i.e. on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_st_q   <= 1'b0;
      is_wd_q   <= 1'b0;
      data_q    <= 16'h0000;
      adr_lo_q  <= '0;
      adr_hi_q  <= '0;
      lo_byte_q <= 8'h00;
      res_data  <= 16'h0000;
    end else begin
      if (accept) begin
        is_st_q  <= (sched_op == OP_STB) || (sched_op == OP_STW);
        is_wd_q  <= (sched_op == OP_LDW) || (sched_op == OP_STW);
        data_q   <= sched_data;
        adr_lo_q <= lsu_adr;
        adr_hi_q <= adr_hi_calc;
      end
      if ((state == ST_LO) && mem_rdy && !is_st_q) begin
        lo_byte_q <= mem_din;
        if (!is_wd_q) res_data <= {8'h00, mem_din};
      end
      if ((state == ST_HI) && mem_rdy && !is_st_q) begin
        res_data <= {mem_din, lo_byte_q};
      end
    end
  end

endmodule

// File: tb/tb_lsu_bus_unit.sv
// Self-checking bench for lsu_bus_unit: directed scenarios followed by randomized ops
// checked cycle by cycle against an operation-level reference model.
module tb_lsu_bus_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lsu_adr;
  logic        sched_req;
  logic [1:0]  sched_op;
  logic        sched_wrap;
  logic [15:0] sched_data;
  logic        sched_busy;
  logic        res_valid;
  logic [15:0] res_data;
  logic [15:0] mem_adr;
  logic [7:0]  mem_dout;
  logic        mem_we;
  logic        mem_req;
  logic [7:0]  mem_din;
  logic        mem_rdy;

  int total  = 0;
  int passed = 0;
  logic [15:0] exp_res;

  always #5 clk = ~clk;

  lsu_bus_unit #(.ADR_W(16), .WRAP_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .lsu_adr    (lsu_adr),
    .sched_req  (sched_req),
    .sched_op   (sched_op),
    .sched_wrap (sched_wrap),
    .sched_data (sched_data),
    .sched_busy (sched_busy),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .mem_adr    (mem_adr),
    .mem_dout   (mem_dout),
    .mem_we     (mem_we),
    .mem_req    (mem_req),
    .mem_din    (mem_din),
    .mem_rdy    (mem_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Address of the second byte of a word access.
  function automatic logic [15:0] hi_of(input logic [15:0] a, input logic w);
    logic [15:0] r;
    if (w) r = (a & 16'hFF00) | ((a + 16'd1) & 16'h00FF);
    else   r = a + 16'd1;
    return r;
  endfunction

  // Idle cycles with random bus noise; nothing may start or complete.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sched_req  = 1'b0;
      lsu_adr    = 16'($urandom);
      sched_data = 16'($urandom);
      mem_rdy    = 1'($urandom);
      mem_din    = 8'($urandom);
      @(negedge clk);
      chk("idle_req",   mem_req,    1'b0);
      chk("idle_valid", res_valid,  1'b0);
      chk("idle_busy",  sched_busy, 1'b0);
      chk("idle_res",   res_data,   exp_res);
      step();
    end
  endtask

  // Issues one operation and checks every cycle up to and including DONE.
  // Returns at the negedge of the DONE cycle so a caller may chain a request there.
  task automatic run_op(input logic [1:0] op, input logic [15:0] adr, input logic wrap,
                        input logic [15:0] dat, input int w0, input int w1,
                        input logic [7:0] b0, input logic [7:0] b1, input logic spam);
    logic        is_wd;
    logic        is_st;
    logic [15:0] hi;
    int          w;
    is_wd = op[0];
    is_st = op[1];
    hi    = hi_of(adr, wrap);
    sched_req  = 1'b1;
    sched_op   = op;
    lsu_adr    = adr;
    sched_wrap = wrap;
    sched_data = dat;
    step();
    for (int k = 0; k < (is_wd ? 2 : 1); k++) begin
      w = (k == 0) ? w0 : w1;
      for (int i = 0; i <= w; i++) begin
        sched_req = spam;
        if (spam) begin
          sched_op   = 2'($urandom);
          lsu_adr    = 16'($urandom);
          sched_data = 16'($urandom);
          sched_wrap = 1'($urandom);
        end
        mem_rdy = (i == w);
        mem_din = (i != w) ? 8'($urandom) : ((k == 0) ? b0 : b1);
        @(negedge clk);
        chk("beat_req",   mem_req,    1'b1);
        chk("beat_adr",   mem_adr,    (k == 0) ? adr : hi);
        chk("beat_we",    mem_we,     is_st);
        chk("beat_dout",  mem_dout,   (k == 0) ? dat[7:0] : dat[15:8]);
        chk("beat_busy",  sched_busy, 1'b1);
        chk("beat_valid", res_valid,  1'b0);
        step();
      end
    end
    if (!is_st) exp_res = is_wd ? {b1, b0} : {8'h00, b0};
    sched_req = 1'b0;
    mem_rdy   = 1'($urandom);
    mem_din   = 8'($urandom);
    @(negedge clk);
    chk("done_valid", res_valid,  1'b1);
    chk("done_req",   mem_req,    1'b0);
    chk("done_busy",  sched_busy, 1'b0);
    chk("done_res",   res_data,   exp_res);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [15:0] r_adr;
    exp_res    = 16'h0000;
    rst        = 1'b1;
    sched_op   = OP_LDB;
    sched_wrap = 1'b0;

    // Reset held two cycles under random traffic.
    for (int i = 0; i < 2; i++) begin
      sched_req  = 1'($urandom);
      sched_op   = 2'($urandom);
      lsu_adr    = 16'($urandom);
      sched_data = 16'($urandom);
      mem_rdy    = 1'($urandom);
      mem_din    = 8'($urandom);
      @(negedge clk);
      chk("rst_req",   mem_req,    1'b0);
      chk("rst_we",    mem_we,     1'b0);
      chk("rst_valid", res_valid,  1'b0);
      chk("rst_adr",   mem_adr,    16'h0000);
      chk("rst_dout",  mem_dout,   8'h00);
      chk("rst_res",   res_data,   16'h0000);
      chk("rst_busy",  sched_busy, 1'b0);
      step();
    end
    rst = 1'b0;
    idle(2);

    // LDB 0x0200 -> 0x00A5.
    run_op(OP_LDB, 16'h0200, 1'b0, 16'h0000, 0, 0, 8'hA5, 8'h00, 1'b0);
    chk("ldb_a5", res_data, 16'h00A5);
    step();
    idle(1);

    // LDW 0x12FF with page wrap -> second beat at 0x1200, result 0x5634.
    run_op(OP_LDW, 16'h12FF, 1'b1, 16'h0000, 0, 0, 8'h34, 8'h56, 1'b0);
    chk("ldw_wrap", res_data, 16'h5634);
    step();

    // STW 0xFFFF without wrap, two wait states on the first beat; res_data unchanged.
    run_op(OP_STW, 16'hFFFF, 1'b0, 16'hBEEF, 2, 0, 8'h00, 8'h00, 1'b0);
    chk("stw_keep", res_data, 16'h5634);
    step();
    idle(1);

    // Reset during the HI beat of an LDW.
    sched_req  = 1'b1;
    sched_op   = OP_LDW;
    lsu_adr    = 16'h3456;
    sched_wrap = 1'b0;
    step();
    sched_req = 1'b0;
    mem_rdy   = 1'b1;
    mem_din   = 8'h11;
    @(negedge clk);
    chk("abort_lo_adr", mem_adr, 16'h3456);
    step();
    rst     = 1'b1;
    mem_din = 8'h22;
    @(negedge clk);
    chk("abort_hi_adr", mem_adr, 16'h3457);
    step();
    rst     = 1'b0;
    exp_res = 16'h0000;
    @(negedge clk);
    chk("abort_req",   mem_req,    1'b0);
    chk("abort_busy",  sched_busy, 1'b0);
    chk("abort_valid", res_valid,  1'b0);
    chk("abort_res",   res_data,   16'h0000);
    step();
    idle(2);
    run_op(OP_LDB, 16'h0042, 1'b0, 16'h0000, 1, 0, 8'h7E, 8'h00, 1'b0);
    chk("after_abort", res_data, 16'h007E);
    step();

    // Requests spammed during an LDW are ignored; an LDB issued in DONE is taken at once.
    run_op(OP_LDW, 16'h0A10, 1'b0, 16'h0000, 1, 1, 8'hC3, 8'h3C, 1'b1);
    run_op(OP_LDB, 16'h0B20, 1'b0, 16'h0000, 0, 0, 8'h99, 8'h00, 1'b0);
    run_op(OP_STB, 16'h0B21, 1'b0, 16'h1234, 0, 0, 8'h00, 8'h00, 1'b0);
    step();

    // Randomized operations.
    for (int n = 0; n < 60; n++) begin
      r_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       r_adr = 16'($urandom);
        1:       r_adr = {8'($urandom), 8'hFF};
        default: r_adr = 16'hFFFF;
      endcase
      run_op(r_op, r_adr, 1'($urandom), 16'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 2),
             8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        step();
        idle($urandom_range(0, 2));
      end
    end
    step();
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
